// File: rtl/enokida_mem_if.sv
// Cache-to-memory request/grant/rvalid bus (RI5CY data protocol).
// The cache drives the request side; the responder answers with gnt/rvalid/rdata.
`timescale 1ns/1ps
interface enokida_mem_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                      mem_req_i;
  logic [ADDR_WIDTH-1:0]     mem_addr_i;
  logic                      mem_we_i;
  logic [DATA_WIDTH/8-1:0]   mem_be_i;
  logic [DATA_WIDTH-1:0]     mem_wdata_i;
  logic                      mem_gnt_o;
  logic                      mem_rvalid_o;
  logic [DATA_WIDTH-1:0]     mem_rdata_o;

  modport master (
    output mem_req_i, mem_addr_i, mem_we_i, mem_be_i, mem_wdata_i,
    input  mem_gnt_o, mem_rvalid_o, mem_rdata_o
  );

  modport slave (
    input  mem_req_i, mem_addr_i, mem_we_i, mem_be_i, mem_wdata_i,
    output mem_gnt_o, mem_rvalid_o, mem_rdata_o
  );
endinterface

// File: rtl/enokida_mem_responder.sv
// Memory-side responder: grants cache requests after a programmable stall and
// returns responses from a word-addressed RAM after a fixed latency.
`timescale 1ns/1ps
module enokida_mem_responder #(
  parameter int ADDR_WIDTH      = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int MEM_DEPTH_WORDS = 1024,
  parameter int GNT_STALL       = 0,
  parameter int RESP_LATENCY    = 2
) (
  input  logic               clk,
  input  logic               rst,
  enokida_mem_if.slave       bus,
  output logic [3:0]         outstanding_o
);

  localparam int IDX_W = $clog2(MEM_DEPTH_WORDS);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(GNT_STALL + 2);
  localparam logic [CNT_W-1:0] STALL_MATCH = CNT_W'(GNT_STALL);

  typedef enum logic [0:0] {IDLE, STALL} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    gnt_s;
  logic [IDX_W-1:0]        idx_s;
  logic [RESP_LATENCY-1:0] pv_q, pv_d;
  logic [DATA_WIDTH-1:0]   pd_q [RESP_LATENCY];
  logic [DATA_WIDTH-1:0]   pd_d [RESP_LATENCY];
  logic [3:0]              out_q, out_d;
  logic [DATA_WIDTH-1:0]   ram_q [MEM_DEPTH_WORDS];
  logic                    unused_addr_s;

  // Offset bits and bits above the RAM index are don't-care: the space wraps.
  assign idx_s         = bus.mem_addr_i[2 +: IDX_W];
  assign unused_addr_s = ^bus.mem_addr_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mem_req_i) begin
          if (GNT_STALL == 0) begin
            gnt_s = 1'b1;
          end else begin
            state_d = STALL;
            cnt_d   = CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      STALL: begin
        if (!bus.mem_req_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == STALL_MATCH) begin
          gnt_s   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (rst) begin
      gnt_s = 1'b0;
    end else begin
      gnt_s = gnt_s & bus.mem_req_i;
    end
  end

  // Response pipeline: stage 0 captures the granted transaction, last stage drives the bus.
  always_comb begin
    pv_d[0] = gnt_s;
    pd_d[0] = (gnt_s && !bus.mem_we_i) ? ram_q[idx_s] : '0;
    for (int i = 1; i < RESP_LATENCY; i++) begin
      pv_d[i] = pv_q[i-1];
      pd_d[i] = pd_q[i-1];
    end
    out_d = out_q + 4'(gnt_s) - 4'(pv_q[RESP_LATENCY-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pv_q    <= '0;
      out_q   <= 4'd0;
      for (int i = 0; i < RESP_LATENCY; i++) begin
        pd_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pv_q    <= pv_d;
      out_q   <= out_d;
      for (int i = 0; i < RESP_LATENCY; i++) begin
        pd_q[i] <= pd_d[i];
      end
    end
  end

  // RAM contents survive reset; a grant cannot occur while rst is high.
  always_ff @(posedge clk) begin
    if (gnt_s && bus.mem_we_i) begin
      for (int b = 0; b < BE_W; b++) begin
        if (bus.mem_be_i[b]) begin
          ram_q[idx_s][8*b +: 8] <= bus.mem_wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign bus.mem_gnt_o    = gnt_s;
  assign bus.mem_rvalid_o = pv_q[RESP_LATENCY-1];
  assign bus.mem_rdata_o  = pd_q[RESP_LATENCY-1];
  assign outstanding_o    = out_q;

endmodule

// File: tb/tb_enokida_mem_responder.sv
// Randomized self-checking bench: three responder configurations checked
// against a transaction-level scoreboard and a word-array memory model.
`timescale 1ns/1ps
module tb_enokida_mem_responder;

  localparam int NDUT = 3;

  typedef struct {
    int          d;
    longint      due;
    logic [31:0] data;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_s   [NDUT];
  logic        we_s    [NDUT];
  logic [15:0] addr_s  [NDUT];
  logic [3:0]  be_s    [NDUT];
  logic [31:0] wdata_s [NDUT];
  logic        gnt_s   [NDUT];
  logic        rvalid_s[NDUT];
  logic [31:0] rdata_s [NDUT];
  logic [3:0]  outst_s [NDUT];

  resp_t       exp_q[$];
  logic [31:0] mm [NDUT][64];
  logic [31:0] last_rd [NDUT];
  int          peak [NDUT];
  int          errors = 0;
  int          checks = 0;
  longint      cyc = 0;
  bit          chk_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // dut 0: stall 0 / latency 2, dut 1: stall 3 / latency 2, dut 2: stall 0 / latency 3
  for (genvar g = 0; g < NDUT; g++) begin : gen_dut
    enokida_mem_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus_if ();
    enokida_mem_responder #(
      .ADDR_WIDTH(16), .DATA_WIDTH(32), .MEM_DEPTH_WORDS(1024),
      .GNT_STALL(g == 1 ? 3 : 0), .RESP_LATENCY(g == 2 ? 3 : 2)
    ) dut (
      .clk(clk), .rst(rst), .bus(bus_if), .outstanding_o(outst_s[g])
    );
    assign bus_if.mem_req_i   = req_s[g];
    assign bus_if.mem_addr_i  = addr_s[g];
    assign bus_if.mem_we_i    = we_s[g];
    assign bus_if.mem_be_i    = be_s[g];
    assign bus_if.mem_wdata_i = wdata_s[g];
    assign gnt_s[g]    = bus_if.mem_gnt_o;
    assign rvalid_s[g] = bus_if.mem_rvalid_o;
    assign rdata_s[g]  = bus_if.mem_rdata_o;
  end

  function automatic int stall_of(int d);
    return (d == 1) ? 3 : 0;
  endfunction

  function automatic int lat_of(int d);
    return (d == 2) ? 3 : 2;
  endfunction

  function automatic int pending(int d);
    int n;
    n = 0;
    foreach (exp_q[i]) if (exp_q[i].d == d) n++;
    return n;
  endfunction

  task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard: outstanding count, response order/timing/data, idle rdata.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < NDUT; d++) begin
        automatic int n  = 0;
        automatic int fi = -1;
        foreach (exp_q[i]) begin
          if (exp_q[i].d == d) begin
            n++;
            if (fi < 0) fi = i;
          end
        end
        check_val($sformatf("outstanding%0d", d), 32'(outst_s[d]), 32'(n));
        if (int'(outst_s[d]) > peak[d]) peak[d] = int'(outst_s[d]);
        if (rvalid_s[d]) begin
          if (fi < 0) begin
            check_val($sformatf("spurious_rvalid%0d", d), 32'(rvalid_s[d]), 32'd0);
          end else begin
            check_val($sformatf("resp_cycle%0d", d), 32'(cyc), 32'(exp_q[fi].due));
            check_val($sformatf("rdata%0d", d), rdata_s[d], exp_q[fi].data);
            last_rd[d] = rdata_s[d];
            exp_q.delete(fi);
          end
        end else begin
          check_val($sformatf("rdata_idle%0d", d), rdata_s[d], 32'd0);
          if (fi >= 0 && exp_q[fi].due <= cyc) begin
            check_val($sformatf("missing_rvalid%0d", d), 32'(rvalid_s[d]), 32'd1);
            exp_q.delete(fi);
          end
        end
      end
    end
  end

  // Entered just after a rising edge; leaves req high so calls can run back-to-back.
  task automatic issue(int d, bit we, logic [15:0] a, logic [3:0] be, logic [31:0] wd);
    bit          g;
    longint      gc;
    int          idx;
    logic [31:0] rd;
    g  = 1'b0;
    gc = 0;
    we_s[d] = we; addr_s[d] = a; be_s[d] = be; wdata_s[d] = wd; req_s[d] = 1'b1;
    for (int k = 0; k <= stall_of(d); k++) begin
      @(negedge clk);
      check_val($sformatf("gnt_timing%0d", d), 32'(gnt_s[d]),
                (k == stall_of(d)) ? 32'd1 : 32'd0);
      if (gnt_s[d]) begin
        g  = 1'b1;
        gc = cyc;
        break;
      end
      if (k < stall_of(d)) begin
        @(posedge clk);
        #1;
      end
    end
    idx = int'(a[7:2]);
    rd  = mm[d][idx];
    @(posedge clk);
    if (g) begin
      exp_q.push_back('{d: d, due: gc + longint'(lat_of(d)), data: we ? 32'd0 : rd});
      if (we) begin
        for (int b = 0; b < 4; b++) if (be[b]) mm[d][idx][8*b +: 8] = wd[8*b +: 8];
      end
    end
    #1;
    if (!g) req_s[d] = 1'b0;
  endtask

  task automatic idle(int d, int n);
    req_s[d] = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(int d);
    req_s[d] = 1'b0;
    for (int i = 0; i < 20 && pending(d) != 0; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    for (int d = 0; d < NDUT; d++) req_s[d] = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    exp_q.delete();
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [15:0] rand_addr();
    logic [3:0] hi;
    logic [5:0] w;
    logic [1:0] lo;
    hi = 4'($urandom);
    w  = 6'($urandom);
    lo = 2'($urandom);
    return {hi, 4'h0, w, lo};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      req_s[d] = 1'b0; we_s[d] = 1'b0; addr_s[d] = 16'h0; be_s[d] = 4'h0;
      wdata_s[d] = 32'h0; peak[d] = 0; last_rd[d] = 32'h0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check_val($sformatf("reset_gnt%0d", d), 32'(gnt_s[d]), 32'd0);
      check_val($sformatf("reset_rvalid%0d", d), 32'(rvalid_s[d]), 32'd0);
    end
    @(posedge clk);
    #1;

    // Preload the 64-word window every test address maps into.
    for (int d = 0; d < NDUT; d++) begin
      for (int i = 0; i < 64; i++) begin
        issue(d, 1'b1, 16'(i * 4), 4'hF, $urandom);
      end
      drain(d);
    end

    // Write then read, byte-enable merge, address wrap.
    issue(0, 1'b1, 16'h0040, 4'hF, 32'hDEADBEEF);
    issue(0, 1'b0, 16'h0040, 4'h0, 32'h0);
    drain(0);
    check_val("wr_rd", last_rd[0], 32'hDEADBEEF);
    issue(0, 1'b1, 16'h0010, 4'hF, 32'h11223344);
    issue(0, 1'b1, 16'h0010, 4'b0101, 32'hAABBCCDD);
    issue(0, 1'b0, 16'h0010, 4'h0, 32'h0);
    drain(0);
    check_val("be_merge", last_rd[0], 32'h11BB33DD);
    issue(0, 1'b1, 16'h1003, 4'hF, 32'h5A5A5A5A);
    issue(0, 1'b0, 16'h0000, 4'h0, 32'h0);
    drain(0);
    check_val("wrap", last_rd[0], 32'h5A5A5A5A);
    peak[0] = 0;
    for (int i = 0; i < 4; i++) issue(0, 1'b0, 16'(i * 4), 4'h0, 32'h0);
    drain(0);
    check_val("peak_lat2", 32'(peak[0]), 32'd2);

    // Stalled grant, then a request abandoned before its grant.
    issue(1, 1'b0, 16'h0040, 4'h0, 32'h0);
    drain(1);
    we_s[1] = 1'b1; addr_s[1] = 16'h0044; be_s[1] = 4'hF; wdata_s[1] = 32'hBADBAD00;
    req_s[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("abandon_gnt", 32'(gnt_s[1]), 32'd0);
      @(posedge clk);
      #1;
      if (k == 1) req_s[1] = 1'b0;
    end
    issue(1, 1'b0, 16'h0044, 4'h0, 32'h0);
    drain(1);

    // Pipelined reads with latency 3.
    for (int i = 0; i < 4; i++) issue(2, 1'b1, 16'(i * 4), 4'hF, 32'(i + 1));
    drain(2);
    peak[2] = 0;
    for (int i = 0; i < 4; i++) issue(2, 1'b0, 16'(i * 4), 4'h0, 32'h0);
    drain(2);
    check_val("peak_lat3", 32'(peak[2]), 32'd3);
    check_val("pipe_last", last_rd[2], 32'd4);

    // Reset while a read is in flight: response dropped, RAM kept.
    issue(2, 1'b0, 16'h0004, 4'h0, 32'h0);
    do_reset();
    idle(2, 6);
    @(negedge clk);
    check_val("rst_outstanding", 32'(outst_s[2]), 32'd0);
    @(posedge clk);
    #1;
    issue(2, 1'b0, 16'h0004, 4'h0, 32'h0);
    drain(2);
    check_val("ram_kept", last_rd[2], 32'd2);

    // Random traffic with random gaps.
    for (int d = 0; d < NDUT; d++) begin
      for (int t = 0; t < 80; t++) begin
        int gap;
        issue(d, 1'($urandom), rand_addr(), 4'($urandom), $urandom);
        gap = int'($urandom_range(0, 3));
        if (gap > 1) idle(d, gap - 1);
      end
      drain(d);
    end

    idle(0, 4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
